// File: rtl/inst_fetcher_pkg.sv
// Opcode constants, immediate extraction and fetch FSM encodings shared by the fetcher and Issue.
// No logic of its own; imported by inst_fetcher.
// Immediates are sign-extended exactly as Issue decodes them.
package inst_fetcher_pkg;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_WAIT   = 2'd1,
      ST_JSTALL = 2'd2,
      ST_DRAIN  = 2'd3
   } fetch_state_t;

   function automatic logic [31:0] imm_b(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] inst);
      return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/inst_fetcher_icache.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup, single write port for fills.
// Latency: hit/hit_data same cycle as lookup_addr; fill visible the cycle after fill_en.
// Backpressure: none; fills are accepted every cycle fill_en is high. Valid bits clear only on reset.
module inst_fetcher_icache #(
   parameter int LINES = 64
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [29:0] lookup_addr,
   output logic        hit,
   output logic [31:0] hit_data,
   input  logic        fill_en,
   input  logic [29:0] fill_addr,
   input  logic [31:0] fill_data
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 30 - IDX_W;

   logic [LINES-1:0] line_vld;
   logic [TAG_W-1:0] line_tag [LINES];
   logic [31:0]      line_dat [LINES];
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;

   // Addresses arrive as word addresses, so the index is the low bits directly.
   assign rd_idx   = lookup_addr[IDX_W-1:0];
   assign wr_idx   = fill_addr[IDX_W-1:0];
   assign hit      = line_vld[rd_idx] && (line_tag[rd_idx] == lookup_addr[29:IDX_W]);
   assign hit_data = line_dat[rd_idx];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         line_vld <= '0;
      end else if (fill_en) begin
         line_vld[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (fill_en) begin
         line_tag[wr_idx] <= fill_addr[29:IDX_W];
         line_dat[wr_idx] <= fill_data;
      end
   end

endmodule

// File: rtl/inst_fetcher.sv
// PC holder and fetch FSM feeding Issue; static predecode of JAL/B-type, JALR stalls until _clear. ICACHE_EN adds an I-cache.
// Latency: memory latency + 1 from request to push; cache hit pushes the cycle after lookup.
// Backpressure: a fetch starts only with _need_inst high, one outstanding request; rdy_in low freezes everything.
module inst_fetcher
   import inst_fetcher_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0
`ifdef ICACHE_EN
   ,parameter int ICACHE_LINES = 64
`endif
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        _clear,
   input  logic [31:0] _clear_pc,
   input  logic        _need_inst,
   output logic [31:0] _inst_out,
   output logic        _inst_ready_out,
   output logic [31:0] _inst_addr_out,
   output logic [31:0] _jalr_rd,
   output logic        _mem_req,
   output logic [31:0] _mem_addr,
   input  logic        _mem_valid,
   input  logic [31:0] _mem_data
);

   fetch_state_t state, state_nxt;
   logic [31:0]  pc, pc_nxt;
   logic [31:0]  inst_nxt, iaddr_nxt, jalr_nxt, maddr_nxt;
   logic         ready_nxt, req_nxt;
   logic         cache_hit;
   logic [31:0]  cache_dat;
   logic [31:0]  resp_word;
   logic         take;

`ifdef ICACHE_EN
   logic fill_en;
   // Drained responses still fill: the data is valid for the latched request address.
   assign fill_en = rdy_in && _mem_valid && (state == ST_WAIT || state == ST_DRAIN);

   inst_fetcher_icache #(.LINES(ICACHE_LINES)) u_icache (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .lookup_addr (pc[31:2]),
      .hit         (cache_hit),
      .hit_data    (cache_dat),
      .fill_en     (fill_en),
      .fill_addr   (_mem_addr[31:2]),
      .fill_data   (_mem_data)
   );
`else
   assign cache_hit = 1'b0;
   assign cache_dat = 32'h0;
`endif

   assign resp_word = (state == ST_WAIT) ? _mem_data : cache_dat;
   assign take      = !_clear && (((state == ST_WAIT) && _mem_valid) ||
                                  ((state == ST_FETCH) && _need_inst && cache_hit));

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= ST_FETCH;
      end else if (rdy_in) begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (_clear) begin
         // The memory controller cannot cancel, so an unanswered request must be drained.
         if ((state == ST_WAIT || state == ST_DRAIN) && !_mem_valid) state_nxt = ST_DRAIN;
         else state_nxt = ST_FETCH;
      end else if (take) begin
         state_nxt = (resp_word[6:0] == OP_JALR) ? ST_JSTALL : ST_FETCH;
      end else begin
         case (state)
            ST_FETCH: if (_need_inst) state_nxt = ST_WAIT;
            ST_DRAIN: if (_mem_valid) state_nxt = ST_FETCH;
            default:  state_nxt = state;
         endcase
      end
   end

   always_comb begin
      pc_nxt    = pc;
      inst_nxt  = _inst_out;
      iaddr_nxt = _inst_addr_out;
      ready_nxt = 1'b0;
      jalr_nxt  = _jalr_rd;
      req_nxt   = _mem_req;
      maddr_nxt = _mem_addr;
      if (_clear) begin
         pc_nxt = _clear_pc;
         if ((state == ST_WAIT || state == ST_DRAIN) && _mem_valid) req_nxt = 1'b0;
      end else if (take) begin
         inst_nxt  = resp_word;
         iaddr_nxt = pc;
         ready_nxt = 1'b1;
         req_nxt   = 1'b0;
         case (resp_word[6:0])
            OP_JAL:    pc_nxt   = pc + imm_j(resp_word);
            OP_BRANCH: pc_nxt   = pc + imm_b(resp_word);
            OP_JALR:   jalr_nxt = pc + 32'd4;
            default:   pc_nxt   = pc + 32'd4;
         endcase
      end else if (state == ST_FETCH && _need_inst) begin
         req_nxt   = 1'b1;
         maddr_nxt = pc;
      end else if (state == ST_DRAIN && _mem_valid) begin
         req_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pc              <= RESET_PC;
         _inst_out       <= 32'h0;
         _inst_addr_out  <= 32'h0;
         _inst_ready_out <= 1'b0;
         _jalr_rd        <= 32'h0;
         _mem_req        <= 1'b0;
         _mem_addr       <= 32'h0;
      end else if (rdy_in) begin
         pc              <= pc_nxt;
         _inst_out       <= inst_nxt;
         _inst_addr_out  <= iaddr_nxt;
         _inst_ready_out <= ready_nxt;
         _jalr_rd        <= jalr_nxt;
         _mem_req        <= req_nxt;
         _mem_addr       <= maddr_nxt;
      end
   end

endmodule
